// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converter pair (forward and reverse double-dabble).
// Holds the FSM state encoding, digit geometry and the per-digit adjust constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int DIGIT_W    = 4;
   localparam int BCD_DIGITS = 3;
   localparam int BCD_W      = DIGIT_W * BCD_DIGITS;

   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
   localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT  = 4'd9;

   // True when every packed nibble is a legal decimal digit.
   function automatic logic bcd_valid(input logic [BCD_W-1:0] value);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (value[d*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit of the reverse double-dabble correction: digits of 8 or more lose 3.
// Purely combinational; the converter instantiates one per digit.
module bcd_digit_sub3
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= ADJ_THRESH) begin
         adj = digit - ADJ_VAL;
      end
   end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Sequential 3-digit BCD to binary converter using reverse double-dabble, N shifts per result.
// Optional macro BCD_CHECK_EN rejects non-decimal digits with an immediate error result.
module bcd_to_bin_converter
   import bcd_pkg::*;
#(
   parameter int N = 10
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           convierte,
   input  logic [3:0]     Icentenas,
   input  logic [3:0]     Idecenas,
   input  logic [3:0]     Iunidades,
   output logic [N-1:0]   OUT,
   output logic           fin,
   output logic           listo,
   output logic           error
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t             state;
   logic [BCD_W-1:0]   bcdReg;
   logic [N-1:0]       binReg;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   bcdShift;
   logic [BCD_W-1:0]   bcdAdj;
   logic [N-1:0]       binShift;
   logic [BCD_W-1:0]   digitsIn;

   assign digitsIn = {Icentenas, Idecenas, Iunidades};

   // The BCD register's LSB falls into the binary MSB; a zero enters the BCD MSB.
   assign bcdShift = {1'b0, bcdReg[BCD_W-1:1]};
   assign binShift = {bcdReg[0], binReg[N-1:1]};

   for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
      bcd_digit_sub3 u_sub3 (
         .digit (bcdShift[d*DIGIT_W +: DIGIT_W]),
         .adj   (bcdAdj[d*DIGIT_W +: DIGIT_W])
      );
   end

`ifdef BCD_CHECK_EN
   logic errPend;
`endif

   // listo is held low through the fin cycle, so a start can never overlap a result pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         bcdReg <= '0;
         binReg <= '0;
         cnt    <= '0;
         OUT    <= '0;
         fin    <= 1'b0;
         listo  <= 1'b1;
`ifdef BCD_CHECK_EN
         error   <= 1'b0;
         errPend <= 1'b0;
`endif
      end else begin
         fin <= 1'b0;
         case (state)
            IDLE: begin
               if (listo && convierte) begin
                  bcdReg <= digitsIn;
                  binReg <= '0;
                  cnt    <= '0;
                  listo  <= 1'b0;
`ifdef BCD_CHECK_EN
                  if (!bcd_valid(digitsIn)) begin
                     errPend <= 1'b1;
                     state   <= DONE;
                  end else begin
                     errPend <= 1'b0;
                     state   <= SHIFT;
                  end
`else
                  state  <= SHIFT;
`endif
               end else begin
                  listo <= 1'b1;
               end
            end

            SHIFT: begin
               bcdReg <= bcdAdj;
               binReg <= binShift;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state <= DONE;
               end
            end

            DONE: begin
               fin   <= 1'b1;
               state <= IDLE;
`ifdef BCD_CHECK_EN
               OUT   <= errPend ? '0 : binReg;
               error <= errPend;
`else
               OUT   <= binReg;
`endif
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef BCD_CHECK_EN
   assign error = 1'b0;
`endif

endmodule
